// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared symbol codes and FSM state type for the transmit symbol scheduler.
//   K_COM/K_SKP/K_STP/K_END/K_EDB : 8b10b K-code byte values (sent with is_k=1)
//   IDLE_DATA                     : logical idle data byte (sent with is_k=0)
//   state_e                       : scheduler FSM states
package tx_sched_pkg;
    localparam logic [7:0] K_COM     = 8'hBC;
    localparam logic [7:0] K_SKP     = 8'h1C;
    localparam logic [7:0] K_STP     = 8'hFB;
    localparam logic [7:0] K_END     = 8'hFD;
    localparam logic [7:0] K_EDB     = 8'hFE;
    localparam logic [7:0] IDLE_DATA = 8'h00;
    typedef enum logic [1:0] {IDLE, DATA, END, SKP} state_e;
endpackage

// File: rtl/tx_skp_timer.sv
// tx_skp_timer: free-running SKP interval timer raising a single sticky request.
//   clk_i, rst_ni : symbol clock, asynchronous active-low reset
//   en_i          : count enable; low holds the counter at 0 (request is kept)
//   clr_i         : consume the pending request
//   pending_o     : SKP ordered set requested
module tx_skp_timer #(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic pending_o
);
    localparam int CW = $clog2(SKP_INTERVAL);
    localparam logic [CW-1:0] LAST = CW'(SKP_INTERVAL - 1);
    logic [CW-1:0] r_cnt;
    logic          r_pending;
    logic          w_expire;
    assign w_expire  = en_i && (r_cnt == LAST);
    assign pending_o = r_pending;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_cnt     <= (!en_i || w_expire) ? '0 : r_cnt + 1'b1;
            // a fresh expiry wins over a same-cycle clear; repeats collapse into one request
            r_pending <= w_expire || (r_pending && !clr_i);
        end
    end
endmodule

// File: rtl/tx_symbol_scheduler.sv
// tx_symbol_scheduler: picks one symbol per clock for the 8b10b encoder -- framed TLP bytes
// (STP..END), logical idle, EDB-nullified underruns and periodic SKP ordered sets.
// Build option: TX_SCHED_SKP_EN enables the SKP timer/ordered-set logic; otherwise no SKP is sent.
//   clk_i, rst_ni              : symbol clock, asynchronous active-low reset
//   en_i                       : link enable, sampled in IDLE
//   tlp_data_i/valid_i/last_i  : TLP byte source; tlp_ready_o = accepting (state DATA)
//   sym_data_o, sym_is_k_o     : registered symbol to encoder
//   skp_sent_o, underrun_o     : one-cycle event pulses aligned with their symbol
//   busy_o                     : FSM not in IDLE
module tx_symbol_scheduler
    import tx_sched_pkg::*;
#(
    parameter int SKP_INTERVAL = 1180
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [7:0] tlp_data_i,
    input  logic       tlp_valid_i,
    input  logic       tlp_last_i,
    output logic       tlp_ready_o,
    output logic [7:0] sym_data_o,
    output logic       sym_is_k_o,
    output logic       skp_sent_o,
    output logic       underrun_o,
    output logic       busy_o
);
    state_e     r_state;
    logic [7:0] r_sym_data;
    logic       r_sym_is_k;
    logic       r_skp_sent;
    logic       r_underrun;
    logic       w_skp_pending;
`ifdef TX_SCHED_SKP_EN
    logic [1:0] r_skp_idx;
    logic       w_skp_clr;
    assign w_skp_clr = (r_state == IDLE) && w_skp_pending;
    tx_skp_timer #(.SKP_INTERVAL(SKP_INTERVAL)) u_skp_timer (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .en_i      (en_i),
        .clr_i     (w_skp_clr),
        .pending_o (w_skp_pending)
    );
`else
    assign w_skp_pending = 1'b0;
`endif
    assign tlp_ready_o = (r_state == DATA);
    assign busy_o      = (r_state != IDLE);
    assign sym_data_o  = r_sym_data;
    assign sym_is_k_o  = r_sym_is_k;
    assign skp_sent_o  = r_skp_sent;
    assign underrun_o  = r_underrun;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_sym_data <= IDLE_DATA;
            r_sym_is_k <= 1'b0;
            r_skp_sent <= 1'b0;
            r_underrun <= 1'b0;
`ifdef TX_SCHED_SKP_EN
            r_skp_idx  <= 2'd0;
`endif
        end else begin
            r_skp_sent <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    // SKP only starts here, so it never lands inside a packet
                    if (w_skp_pending) begin
                        r_sym_data <= K_COM;
                        r_sym_is_k <= 1'b1;
                        r_state    <= SKP;
`ifdef TX_SCHED_SKP_EN
                        r_skp_idx  <= 2'd1;
`endif
                    end else if (en_i && tlp_valid_i) begin
                        r_sym_data <= K_STP;
                        r_sym_is_k <= 1'b1;
                        r_state    <= DATA;
                    end else begin
                        r_sym_data <= IDLE_DATA;
                        r_sym_is_k <= 1'b0;
                    end
                end
                DATA: begin
                    if (tlp_valid_i) begin
                        r_sym_data <= tlp_data_i;
                        r_sym_is_k <= 1'b0;
                        if (tlp_last_i) r_state <= END;
                    end else begin
                        // source ran dry mid-packet: nullify with EDB
                        r_sym_data <= K_EDB;
                        r_sym_is_k <= 1'b1;
                        r_underrun <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                END: begin
                    r_sym_data <= K_END;
                    r_sym_is_k <= 1'b1;
                    r_state    <= IDLE;
                end
`ifdef TX_SCHED_SKP_EN
                SKP: begin
                    r_sym_data <= K_SKP;
                    r_sym_is_k <= 1'b1;
                    if (r_skp_idx == 2'd3) begin
                        r_skp_sent <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_skp_idx  <= r_skp_idx + 2'd1;
                    end
                end
`endif
                default: begin
                    r_sym_data <= IDLE_DATA;
                    r_sym_is_k <= 1'b0;
                    r_state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// tb_tx_symbol_scheduler: directed self-checking bench for tx_symbol_scheduler (SKP_INTERVAL=16).
module tb_tx_symbol_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] tlp_data;
    logic       tlp_valid;
    logic       tlp_last;
    logic       tlp_ready;
    logic [7:0] sym_data;
    logic       sym_is_k;
    logic       skp_sent;
    logic       underrun;
    logic       busy;
    int         n_chk  = 0;
    int         n_pass = 0;

    tx_symbol_scheduler #(.SKP_INTERVAL(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .tlp_data_i  (tlp_data),
        .tlp_valid_i (tlp_valid),
        .tlp_last_i  (tlp_last),
        .tlp_ready_o (tlp_ready),
        .sym_data_o  (sym_data),
        .sym_is_k_o  (sym_is_k),
        .skp_sent_o  (skp_sent),
        .underrun_o  (underrun),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic do_reset();
        en        = 1'b0;
        tlp_valid = 1'b0;
        tlp_last  = 1'b0;
        tlp_data  = 8'h00;
        rst_n     = 1'b0;
        @(posedge clk);
        #1 rst_n  = 1'b1;
    endtask

    // drive inputs, take one edge, then check {is_k,data} and ready
    task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                       input logic [8:0] exp_sym, input logic exp_rdy, input string tag);
        tlp_valid = v;
        tlp_data  = d;
        tlp_last  = l;
        @(posedge clk);
        #1;
        chk({tag, ".sym"}, {23'd0, sym_is_k, sym_data}, {23'd0, exp_sym});
        chk({tag, ".rdy"}, {31'd0, tlp_ready}, {31'd0, exp_rdy});
    endtask

    initial begin
        en = 1'b0; tlp_valid = 1'b0; tlp_last = 1'b0; tlp_data = 8'h00; rst_n = 1'b0;
        #2;
        chk("rst_async", {19'd0, tlp_ready, busy, skp_sent, underrun, sym_is_k, sym_data}, 32'd0);
        do_reset();
        #1;
        chk("rst_state", {19'd0, tlp_ready, busy, skp_sent, underrun, sym_is_k, sym_data}, 32'd0);

        // 3-byte packet
        do_reset();
        en = 1'b1;
        cyc(1, 8'hA1, 0, 9'h1FB, 1, "p3_stp");
        chk("p3_busy", {31'd0, busy}, 32'd1);
        cyc(1, 8'hA1, 0, 9'h0A1, 1, "p3_b0");
        cyc(1, 8'hA2, 0, 9'h0A2, 1, "p3_b1");
        cyc(1, 8'hA3, 1, 9'h0A3, 0, "p3_b2");
        cyc(0, 8'h00, 0, 9'h1FD, 0, "p3_end");
        cyc(0, 8'h00, 0, 9'h000, 0, "p3_idle");
        chk("p3_busy_end", {31'd0, busy}, 32'd0);

        // back-to-back 2-byte packets, no gap between END and STP
        do_reset();
        en = 1'b1;
        cyc(1, 8'h11, 0, 9'h1FB, 1, "bb_stp0");
        cyc(1, 8'h11, 0, 9'h011, 1, "bb_x0");
        cyc(1, 8'h12, 1, 9'h012, 0, "bb_x1");
        cyc(1, 8'h21, 0, 9'h1FD, 0, "bb_end0");
        cyc(1, 8'h21, 0, 9'h1FB, 1, "bb_stp1");
        cyc(1, 8'h21, 0, 9'h021, 1, "bb_y0");
        cyc(1, 8'h22, 1, 9'h022, 0, "bb_y1");
        cyc(0, 8'h00, 0, 9'h1FD, 0, "bb_end1");
        cyc(0, 8'h00, 0, 9'h000, 0, "bb_idle");

        // underrun after one byte
        do_reset();
        en = 1'b1;
        cyc(1, 8'h55, 0, 9'h1FB, 1, "ur_stp");
        cyc(1, 8'h55, 0, 9'h055, 1, "ur_b0");
        chk("ur_pulse_pre", {31'd0, underrun}, 32'd0);
        cyc(0, 8'h00, 0, 9'h1FE, 0, "ur_edb");
        chk("ur_pulse", {31'd0, underrun}, 32'd1);
        chk("ur_busy", {31'd0, busy}, 32'd0);
        cyc(0, 8'h00, 0, 9'h000, 0, "ur_idle");
        chk("ur_pulse_post", {31'd0, underrun}, 32'd0);

        // enable low: valid alone does not start a packet
        do_reset();
        cyc(1, 8'h66, 1, 9'h000, 0, "dis_idle");

        // asynchronous reset mid-packet discards it without EDB
        do_reset();
        en = 1'b1;
        cyc(1, 8'h77, 0, 9'h1FB, 1, "mr_stp");
        cyc(1, 8'h77, 0, 9'h077, 1, "mr_b0");
        rst_n = 1'b0;
        #1;
        chk("mr_async", {21'd0, tlp_ready, busy, sym_is_k, sym_data}, 32'd0);
        @(posedge clk);
        #1;
        chk("mr_next", {21'd0, tlp_ready, busy, sym_is_k, sym_data}, 32'd0);
        rst_n = 1'b1;

`ifdef TX_SCHED_SKP_EN
        // SKP ordered set starts on cycle 17 after enable
        do_reset();
        en = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            logic [8:0] e;
            e = (i == 17) ? 9'h1BC : (i >= 18 && i <= 20) ? 9'h11C : 9'h000;
            cyc(0, 8'h00, 0, e, 0, $sformatf("skp_c%0d", i));
            if (i >= 16) chk($sformatf("skp_sent_c%0d", i), {31'd0, skp_sent}, {31'd0, i == 20});
        end

        // expiry during a 20-byte packet is deferred to the boundary and beats a waiting packet
        do_reset();
        en = 1'b1;
        cyc(1, 8'h40, 0, 9'h1FB, 1, "sp_stp");
        for (int i = 0; i < 20; i++)
            cyc(1, 8'h40 + 8'(i), i == 19, {1'b0, 8'h40 + 8'(i)}, i != 19, $sformatf("sp_b%0d", i));
        cyc(1, 8'h77, 1, 9'h1FD, 0, "sp_end");
        cyc(1, 8'h77, 1, 9'h1BC, 0, "sp_com");
        cyc(1, 8'h77, 1, 9'h11C, 0, "sp_skp1");
        cyc(1, 8'h77, 1, 9'h11C, 0, "sp_skp2");
        cyc(1, 8'h77, 1, 9'h11C, 0, "sp_skp3");
        chk("sp_sent", {31'd0, skp_sent}, 32'd1);
        cyc(1, 8'h77, 1, 9'h1FB, 1, "sp_stp2");
        cyc(1, 8'h77, 1, 9'h077, 0, "sp_b2");
        cyc(0, 8'h00, 0, 9'h1FD, 0, "sp_end2");
`else
        // no SKP build: COM never appears over 5000 cycles of mixed traffic
        begin
            int n_com = 0;
            int n_sent = 0;
            do_reset();
            en = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                tlp_valid = ($urandom_range(0, 7) != 0);
                tlp_data  = 8'($urandom);
                tlp_last  = ($urandom_range(0, 5) == 0);
                @(posedge clk);
                #1;
                if ({sym_is_k, sym_data} == 9'h1BC) n_com++;
                if (skp_sent) n_sent++;
            end
            chk("noskp_com", n_com, 0);
            chk("noskp_sent", n_sent, 0);
        end
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
